// File: rtl/cpu_div_seq_pkg.sv
// Shared definitions for the sequential RV32M divider.
//   DIV_OP_*    : 2-bit op encodings ([1]=remainder, [0]=unsigned)
//   div_state_e : sequencer state encodings
//   op_is_rem / op_is_unsigned : op field decode helpers
package cpu_div_seq_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    DIV_S_IDLE    = 3'd0,
    DIV_S_CALC    = 3'd1,
    DIV_S_FIX     = 3'd2,
    DIV_S_SPECIAL = 3'd3,
    DIV_S_DONE    = 3'd4
  } div_state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One restoring radix-2 division step (purely combinational).
//   rem          in  XLEN+1  partial remainder before the step
//   dividend_msb in  1       next dividend bit shifted into the remainder
//   divisor      in  XLEN    divisor magnitude
//   rem_next     out XLEN+1  partial remainder after the step
//   q_bit        out 1       quotient bit produced by this step
module cpu_div_step
  import cpu_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;
  logic          ge_s;

  assign shifted_s = {rem[XLEN-1:0], dividend_msb};
  assign diff_s    = shifted_s - {1'b0, divisor};
  // A set top bit would mean the shifted value exceeds XLEN+1 bits, which is
  // always >= the divisor; folding it in keeps the compare exact.
  assign ge_s      = rem[XLEN] | (shifted_s >= {1'b0, divisor});

  // Restore-or-subtract selection.
  always_comb begin
    rem_next = shifted_s;
    q_bit    = 1'b0;
    if (ge_s) begin
      rem_next = diff_s;
      q_bit    = 1'b1;
    end else begin
      rem_next = shifted_s;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Restoring radix-2, one quotient bit per clock; valid/ready on both sides.
//   clk, rst (async, active-high), flush (sync abort)
//   in_valid/in_ready, in_op, in_a (dividend), in_b (divisor)
//   out_valid/out_ready, out_result (quotient or remainder)
//   busy : sequencer not idle
module cpu_div_seq
  import cpu_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int              CW         = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES       = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG    = {1'b1, {(XLEN-1){1'b0}}};

  // Two's complement negation when neg is set, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  div_state_e      state_r, state_s;
  logic [CW-1:0]   count_r;
  logic [XLEN:0]   rem_r;
  logic [XLEN-1:0] dvd_r;      // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] dvs_r;
  logic [1:0]      op_r;
  logic            a_neg_r, b_neg_r, div0_r;
  logic [XLEN-1:0] out_result_r;

  logic            accept_s, div0_s, ovf_s, a_neg_s, b_neg_s, signed_s;
  logic [XLEN:0]   rem_step_s;
  logic            q_bit_s;
  logic [XLEN-1:0] fix_result_s, special_result_s;

  assign in_ready   = (state_r == DIV_S_IDLE) && !flush;
  assign accept_s   = in_valid && in_ready;
  assign out_valid  = (state_r == DIV_S_DONE);
  assign busy       = (state_r != DIV_S_IDLE);
  assign out_result = out_result_r;

  assign signed_s = !op_is_unsigned(in_op);
  assign a_neg_s  = signed_s && in_a[XLEN-1];
  assign b_neg_s  = signed_s && in_b[XLEN-1];
  assign div0_s   = (in_b == ZERO);
  assign ovf_s    = signed_s && (in_a == MIN_NEG) && (in_b == ONES);

  cpu_div_step #(.XLEN(XLEN)) u_step (
    .rem          (rem_r),
    .dividend_msb (dvd_r[XLEN-1]),
    .divisor      (dvs_r),
    .rem_next     (rem_step_s),
    .q_bit        (q_bit_s)
  );

  // Sign fix-up of the magnitude result and special-case result selection.
  always_comb begin
    fix_result_s     = ZERO;
    special_result_s = ZERO;
    if (op_is_rem(op_r)) begin
      fix_result_s = neg_if(rem_r[XLEN-1:0], !op_is_unsigned(op_r) && a_neg_r);
    end else begin
      fix_result_s = neg_if(dvd_r, !op_is_unsigned(op_r) && (a_neg_r ^ b_neg_r));
    end
    // dvd_r holds the raw dividend for special cases.
    if (div0_r) begin
      special_result_s = op_is_rem(op_r) ? dvd_r : ONES;
    end else begin
      special_result_s = op_is_rem(op_r) ? ZERO : dvd_r;
    end
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = DIV_S_IDLE;
    end else begin
      case (state_r)
        DIV_S_IDLE: begin
          if (accept_s) begin
            state_s = (div0_s || ovf_s) ? DIV_S_SPECIAL : DIV_S_CALC;
          end else begin
            state_s = DIV_S_IDLE;
          end
        end
        DIV_S_CALC: begin
          if (count_r == LAST_COUNT) begin
            state_s = DIV_S_FIX;
          end else begin
            state_s = DIV_S_CALC;
          end
        end
        DIV_S_FIX:     state_s = DIV_S_DONE;
        DIV_S_SPECIAL: state_s = DIV_S_DONE;
        DIV_S_DONE: begin
          if (out_ready) begin
            state_s = DIV_S_IDLE;
          end else begin
            state_s = DIV_S_DONE;
          end
        end
        default: state_s = DIV_S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= DIV_S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= {CW{1'b0}};
      rem_r        <= {(XLEN+1){1'b0}};
      dvd_r        <= ZERO;
      dvs_r        <= ZERO;
      op_r         <= 2'b00;
      a_neg_r      <= 1'b0;
      b_neg_r      <= 1'b0;
      div0_r       <= 1'b0;
      out_result_r <= ZERO;
    end else begin
      case (state_r)
        DIV_S_IDLE: begin
          if (accept_s) begin
            op_r    <= in_op;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            div0_r  <= div0_s;
            rem_r   <= {(XLEN+1){1'b0}};
            count_r <= {CW{1'b0}};
            if (div0_s || ovf_s) begin
              dvd_r <= in_a;
              dvs_r <= in_b;
            end else begin
              dvd_r <= neg_if(in_a, a_neg_s);
              dvs_r <= neg_if(in_b, b_neg_s);
            end
          end
        end
        DIV_S_CALC: begin
          rem_r   <= rem_step_s;
          dvd_r   <= {dvd_r[XLEN-2:0], q_bit_s};
          count_r <= count_r + COUNT_ONE;
        end
        DIV_S_FIX: begin
          if (!flush) begin
            out_result_r <= fix_result_s;
          end
        end
        DIV_S_SPECIAL: begin
          if (!flush) begin
            out_result_r <= special_result_s;
          end
        end
        DIV_S_DONE: begin
          out_result_r <= out_result_r;
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_div_seq.sv
// Self-checking bench for cpu_div_seq: directed corner cases, stall, flush,
// reset mid-op and randomized operations against an arithmetic reference.
module tb_cpu_div_seq;
  import cpu_div_seq_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_op = 2'b00;
  logic [XLEN-1:0] in_a = 32'h0;
  logic [XLEN-1:0] in_b = 32'h0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic            busy;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_div_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V divide semantics from plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'h0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Edges from accept (counted as edge 1) until out_valid is seen.
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return XLEN + 2;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int stall,
                        input string tag);
    int n;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    check_eq({tag, "/in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "/latency"}, n, exp_lat);
    check_eq({tag, "/result"}, out_result, exp_res);
    check_eq({tag, "/busy_done"}, {31'b0, busy}, 32'd1);
    check_eq({tag, "/in_ready_done"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "/stall_valid"}, {31'b0, out_valid}, 32'd1);
      check_eq({tag, "/stall_result"}, out_result, exp_res);
      check_eq({tag, "/stall_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "/post_valid"}, {31'b0, out_valid}, 32'd0);
    check_eq({tag, "/post_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        seen;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset/out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset/busy", {31'b0, busy}, 32'd0);
    check_eq("reset/out_result", out_result, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle/in_ready", {31'b0, in_ready}, 32'd1);

    // Directed cases.
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, "divu_100_7");
    run_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 34, 0, "remu_100_7");
    run_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, "div_m7_2");
    run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, "rem_m7_2");
    run_op(DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, "div_7_m2");
    run_op(DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, "rem_7_m2");
    run_op(DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0, "div_5_0");
    run_op(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 2, 0, "remu_5_0");
    run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, "div_ovf");
    run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0, "rem_ovf");
    run_op(DIV_OP_DIVU, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 34, 0, "divu_by_1");
    run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34, 10, "stall");

    // Flush in the 10th CALC cycle.
    in_op = DIV_OP_DIVU;
    in_a = 32'hFFFF_FFF0;
    in_b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("flush/busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush/busy_after", {31'b0, busy}, 32'd0);
    check_eq("flush/valid_after", {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush/no_result", {31'b0, seen}, 32'd0);
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 0, "after_flush");

    // Flush beats a same-cycle request.
    in_op = DIV_OP_DIVU;
    in_a = 32'd9;
    in_b = 32'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check_eq("flush_accept/in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_accept/busy", {31'b0, busy}, 32'd0);

    // Reset asserted mid-CALC.
    in_op = DIV_OP_DIVU;
    in_a = 32'd1000;
    in_b = 32'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_mid/busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid/out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_mid/busy", {31'b0, busy}, 32'd0);
    check_eq("rst_mid/out_result", out_result, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(DIV_OP_REMU, 32'd1000, 32'd7, 32'd6, 34, 0, "after_rst");

    // Randomized operations against the reference.
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'd1;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, ref_div(op, a, b), ref_latency(op, a, b), t % 3, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
